// File: rtl/activation_flow_controller_if.sv
// rtl/activation_flow_controller_if.sv - instruction and accumulator/buffer handshake bundle for the activation flow controller
interface activation_flow_controller_if #(
    parameter int ACC_ADDR_WIDTH = 8,
    parameter int BUF_ADDR_WIDTH = 12,
    parameter int LENGTH_WIDTH   = 8
);
    logic                      enable;
    logic [7:0]                instr_opcode;
    logic [LENGTH_WIDTH-1:0]   instr_length;
    logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr;
    logic [BUF_ADDR_WIDTH-1:0] instr_buffer_addr;
    logic                      instr_enable;
    logic [ACC_ADDR_WIDTH-1:0] acc_to_act_addr;
    logic                      acc_read_enable;
    logic [3:0]                activation_function;
    logic                      is_act_signed;
    logic [BUF_ADDR_WIDTH-1:0] act_to_buf_addr;
    logic                      buf_write_enable;
    logic                      busy;
    logic                      resource_busy;

    modport master (
        output enable, instr_opcode, instr_length, instr_acc_addr, instr_buffer_addr, instr_enable,
        input  acc_to_act_addr, acc_read_enable, activation_function, is_act_signed,
               act_to_buf_addr, buf_write_enable, busy, resource_busy
    );

    modport slave (
        input  enable, instr_opcode, instr_length, instr_acc_addr, instr_buffer_addr, instr_enable,
        output acc_to_act_addr, acc_read_enable, activation_function, is_act_signed,
               act_to_buf_addr, buf_write_enable, busy, resource_busy
    );
endinterface

// File: rtl/activation_flow_controller.sv
// rtl/activation_flow_controller.sv - drains accumulator rows through the activation unit into the unified buffer
module activation_flow_controller #(
    parameter int MATRIX_WIDTH       = 14,
    parameter int ACC_READ_LATENCY   = 1,
    parameter int ACTIVATION_LATENCY = 3,
    parameter int ACC_ADDR_WIDTH     = 8,
    parameter int BUF_ADDR_WIDTH     = 12,
    parameter int LENGTH_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    activation_flow_controller_if.slave  bus
);
    localparam int D = ACC_READ_LATENCY + ACTIVATION_LATENCY;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    if (MATRIX_WIDTH < 1 || ACC_READ_LATENCY < 1 || ACTIVATION_LATENCY < 1) begin : g_param_check
        $error("activation_flow_controller: widths and latencies must be at least 1");
    end

    logic [0:0]                r_state;
    logic [ACC_ADDR_WIDTH-1:0] r_rd_addr;
    logic [BUF_ADDR_WIDTH-1:0] r_buf_addr;
    logic [LENGTH_WIDTH-1:0]   r_left;
    logic [3:0]                r_func;
    logic                      r_signed;
    logic [D:1]                r_vld;
    logic [3:0]                r_func_dl [1:ACC_READ_LATENCY];
    logic                      r_sign_dl [1:ACC_READ_LATENCY];
    logic [BUF_ADDR_WIDTH-1:0] r_addr_dl [1:D];
    logic                      w_rd;
    logic [2:0]                w_unused_opcode;

    assign w_rd            = (r_state == S_RUN);
    assign w_unused_opcode = bus.instr_opcode[7:5];

    // Valid, function/sign and write address travel together down shift registers so a
    // new instruction can start while the previous one's writes are still draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_addr  <= '0;
            r_buf_addr <= '0;
            r_left     <= '0;
            r_func     <= '0;
            r_signed   <= 1'b0;
            r_vld      <= '0;
            for (int i = 1; i <= ACC_READ_LATENCY; i++) begin
                r_func_dl[i] <= '0;
                r_sign_dl[i] <= 1'b0;
            end
            for (int i = 1; i <= D; i++) begin
                r_addr_dl[i] <= '0;
            end
        end else if (bus.enable) begin
            r_vld[1]     <= w_rd;
            r_func_dl[1] <= w_rd ? r_func : 4'd0;
            r_sign_dl[1] <= w_rd & r_signed;
            r_addr_dl[1] <= w_rd ? r_buf_addr : '0;
            for (int i = 2; i <= D; i++) begin
                r_vld[i]     <= r_vld[i-1];
                r_addr_dl[i] <= r_addr_dl[i-1];
            end
            for (int i = 2; i <= ACC_READ_LATENCY; i++) begin
                r_func_dl[i] <= r_func_dl[i-1];
                r_sign_dl[i] <= r_sign_dl[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.instr_enable && (bus.instr_length != '0)) begin
                        r_func     <= bus.instr_opcode[3:0];
                        r_signed   <= bus.instr_opcode[4];
                        r_rd_addr  <= bus.instr_acc_addr;
                        r_buf_addr <= bus.instr_buffer_addr;
                        r_left     <= bus.instr_length;
                        r_state    <= S_RUN;
                    end
                end
                default: begin
                    r_rd_addr  <= r_rd_addr + ACC_ADDR_WIDTH'(1);
                    r_buf_addr <= r_buf_addr + BUF_ADDR_WIDTH'(1);
                    r_left     <= r_left - LENGTH_WIDTH'(1);
                    if (r_left == LENGTH_WIDTH'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.acc_read_enable     = w_rd;
    assign bus.acc_to_act_addr     = w_rd ? r_rd_addr : '0;
    assign bus.activation_function = r_vld[ACC_READ_LATENCY] ? r_func_dl[ACC_READ_LATENCY] : 4'd0;
    assign bus.is_act_signed       = r_vld[ACC_READ_LATENCY] & r_sign_dl[ACC_READ_LATENCY];
    assign bus.buf_write_enable    = r_vld[D];
    assign bus.act_to_buf_addr     = r_vld[D] ? r_addr_dl[D] : '0;
    assign bus.busy                = w_rd;
    assign bus.resource_busy       = w_rd | (|r_vld);
endmodule

// File: tb/tb_activation_flow_controller.sv
// tb/tb_activation_flow_controller.sv - scoreboard bench for activation_flow_controller
module tb_activation_flow_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    activation_flow_controller_if bus ();

    activation_flow_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  rd_q [$];
    logic [11:0] wr_q [$];
    logic [4:0]  fs_q [$];
    logic [4:0]  pend_fs = 5'd0;
    bit          prev_en = 1'b0;
    logic [28:0] snap = '0;
    logic [28:0] cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always_comb cur = {bus.acc_read_enable, bus.acc_to_act_addr, bus.activation_function,
                       bus.is_act_signed, bus.buf_write_enable, bus.act_to_buf_addr,
                       bus.busy, bus.resource_busy};

    always @(negedge clk) begin
        if (rst) begin
            pend_fs = 5'd0;
        end else if (!prev_en) begin
            chk("frozen", 32'(cur), 32'(snap));
        end else begin
            chk("func_sign", 32'({bus.is_act_signed, bus.activation_function}), 32'(pend_fs));
            chk("busy_in_rb", 32'(bus.busy & ~bus.resource_busy), 32'd0);
            if (bus.acc_read_enable) begin
                if (rd_q.size() == 0) chk("unexpected_read", 32'(bus.acc_to_act_addr), 32'hFFFF_FFFF);
                else                  chk("rd_addr", 32'(bus.acc_to_act_addr), 32'(rd_q.pop_front()));
                pend_fs = (fs_q.size() != 0) ? fs_q.pop_front() : 5'h1F;
            end else begin
                pend_fs = 5'd0;
            end
            if (bus.buf_write_enable) begin
                if (wr_q.size() == 0) chk("unexpected_write", 32'(bus.act_to_buf_addr), 32'hFFFF_FFFF);
                else                  chk("wr_addr", 32'(bus.act_to_buf_addr), 32'(wr_q.pop_front()));
            end
        end
        snap    = cur;
        prev_en = bus.enable;
    end

    task automatic drive_instr(input logic [4:0] op, input logic [7:0] acc,
                               input logic [11:0] badr, input logic [7:0] len);
        bus.instr_opcode      = {3'b000, op};
        bus.instr_acc_addr    = acc;
        bus.instr_buffer_addr = badr;
        bus.instr_length      = len;
        bus.instr_enable      = 1'b1;
        for (int k = 0; k < int'(len); k++) begin
            rd_q.push_back(acc + 8'(k));
            wr_q.push_back(badr + 12'(k));
            fs_q.push_back(op);
        end
    endtask

    // Returns one #1 after the accepting edge T, i.e. inside cycle T+1.
    task automatic issue(input logic [4:0] op, input logic [7:0] acc,
                         input logic [11:0] badr, input logic [7:0] len);
        @(posedge clk); #1;
        drive_instr(op, acc, badr, len);
        @(posedge clk); #1;
        bus.instr_enable = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        repeat (12) @(posedge clk);
        #1;
        chk({tag, "_rdq_empty"}, 32'(rd_q.size()), 32'd0);
        chk({tag, "_wrq_empty"}, 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        bus.enable            = 1'b1;
        bus.instr_opcode      = '0;
        bus.instr_acc_addr    = '0;
        bus.instr_buffer_addr = '0;
        bus.instr_length      = '0;
        bus.instr_enable      = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("outputs_in_reset", 32'(cur), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("outputs_idle", 32'(cur), 32'd0);
        end

        issue(5'b10011, 8'd5, 12'd100, 8'd4);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("busy@T+%0d", c), 32'(bus.busy), 32'(c <= 4));
            chk($sformatf("rden@T+%0d", c), 32'(bus.acc_read_enable), 32'(c <= 4));
            chk($sformatf("wren@T+%0d", c), 32'(bus.buf_write_enable), 32'(c >= 5 && c <= 8));
            chk($sformatf("rbusy@T+%0d", c), 32'(bus.resource_busy), 32'(c <= 8));
        end
        drain_and_check("single");

        issue(5'b00111, 8'd10, 12'd200, 8'd4);
        repeat (3) @(posedge clk);
        issue(5'b01010, 8'd20, 12'd300, 8'd2);
        drain_and_check("back_to_back");

        @(posedge clk); #1;
        drive_instr(5'b10011, 8'd5, 12'd100, 8'd4);
        @(posedge clk); #1;
        bus.instr_acc_addr = 8'd50;
        bus.instr_length   = 8'd2;
        repeat (4) @(posedge clk);
        #1;
        bus.instr_enable = 1'b0;
        drain_and_check("held_enable");

        issue(5'b10011, 8'd5, 12'd100, 8'd4);
        @(posedge clk); @(posedge clk); #1;
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.enable = 1'b1;
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("stall_rbusy@T+%0d", c), 32'(bus.resource_busy), 32'(c <= 11));
        end
        drain_and_check("stall");

        issue(5'b00001, 8'hFF, 12'hFFF, 8'd3);
        drain_and_check("wrap");

        issue(5'b00010, 8'd7, 12'd7, 8'd0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("len0_busy", 32'(bus.busy), 32'd0);
            chk("len0_rbusy", 32'(bus.resource_busy), 32'd0);
        end

        issue(5'b10011, 8'd5, 12'd100, 8'd4);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        fs_q.delete();
        @(negedge clk);
        chk("outputs_mid_reset", 32'(cur), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("no_write_after_reset", 32'(bus.buf_write_enable), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
